// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Resolves DMEM wait states, mispredict redirects (plus trailing IF/ID bubbles)
// and load-use interlocks, and keeps saturating performance counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W            = 32,
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mispred,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  input  logic             i_wb_valid,
  input  logic             i_wb_bubble,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_idex_stall,
  output logic             o_exmem_stall,
  output logic             o_memwb_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_exmem_flush,
  output logic             o_memwb_flush,
  output logic [1:0]       o_state,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_cnt_cycle,
  output logic [CNT_W-1:0] o_cnt_retire,
  output logic [CNT_W-1:0] o_cnt_stall,
  output logic [CNT_W-1:0] o_cnt_flush
);

  localparam int unsigned WAIT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0]  BUB_LOAD = 3'(REDIRECT_BUBBLES);
  localparam logic        HAS_BUB  = (REDIRECT_BUBBLES != 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_REDIRECT = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        bub_q, bub_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_cycle_q, cnt_retire_q, cnt_stall_q, cnt_flush_q;

  logic wait_c, mp_c, lu_c;

  // Hazard conditions decoded from the current pipeline contents.
  always_comb begin
    wait_c = i_mem_req & ~i_mem_ready;
    mp_c   = i_ex_valid & i_ex_mispred;
    lu_c   = i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0) &
             ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
              (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));
  end

  // Prioritised stall/flush decode: wait > mispredict > load-use > redirect bubble.
  always_comb begin
    o_pc_stall    = 1'b0;
    o_ifid_stall  = 1'b0;
    o_idex_stall  = 1'b0;
    o_exmem_stall = 1'b0;
    o_memwb_stall = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    o_memwb_flush = 1'b0;
    if (i_reset) begin
      if (wait_c) begin
        o_pc_stall    = 1'b1;
        o_ifid_stall  = 1'b1;
        o_idex_stall  = 1'b1;
        o_exmem_stall = 1'b1;
        o_memwb_flush = 1'b1;
      end else if (mp_c) begin
        o_ifid_flush = 1'b1;
        o_idex_flush = 1'b1;
      end else if (lu_c) begin
        o_pc_stall   = 1'b1;
        o_ifid_stall = 1'b1;
        o_idex_flush = 1'b1;
      end else if (state_q == ST_REDIRECT) begin
        o_ifid_flush = 1'b1;
      end
    end
  end

  // Next-state logic: sequencing of wait states, redirect bubbles and the timeout flag.
  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    wait_d  = '0;
    tmo_d   = tmo_q;
    if (wait_c) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      if (wait_d == WAIT_MAX) tmo_d = 1'b1;
    end
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (wait_c) begin
          state_d = ST_MEM_WAIT;
        end else if (mp_c && HAS_BUB) begin
          state_d = ST_REDIRECT;
          bub_d   = BUB_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (wait_c) begin
          state_d = ST_MEM_WAIT;
          bub_d   = 3'd0;
        end else if (mp_c) begin
          bub_d = BUB_LOAD;
        end else if (bub_q <= 3'd1) begin
          state_d = ST_RUN;
          bub_d   = 3'd0;
        end else begin
          bub_d = bub_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        bub_d   = 3'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      bub_q   <= 3'd0;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  // Saturating performance counters.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_cycle_q  <= '0;
      cnt_retire_q <= '0;
      cnt_stall_q  <= '0;
      cnt_flush_q  <= '0;
    end else begin
      cnt_cycle_q  <= sat_inc(cnt_cycle_q, 1'b1);
      cnt_retire_q <= sat_inc(cnt_retire_q, i_wb_valid & ~i_wb_bubble);
      cnt_stall_q  <= sat_inc(cnt_stall_q, o_pc_stall);
      cnt_flush_q  <= sat_inc(cnt_flush_q, mp_c & ~wait_c);
    end
  end

  assign o_state       = state_q;
  assign o_mem_timeout = tmo_q;
  assign o_cnt_cycle   = cnt_cycle_q;
  assign o_cnt_retire  = cnt_retire_q;
  assign o_cnt_stall   = cnt_stall_q;
  assign o_cnt_flush   = cnt_flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model of the stall/flush rules.
module tb_hazard_ctrl;

  localparam int unsigned BUB = 2;
  localparam int unsigned MT  = 4;
  localparam longint unsigned MAX32 = 64'hFFFF_FFFF;
  localparam longint unsigned MAX4  = 64'd15;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_valid, ex_mem_read, ex_mispred;
  logic       mem_req, mem_ready, wb_valid, wb_bubble;

  logic        pc_st, ifid_st, idex_st, exmem_st, memwb_st;
  logic        ifid_fl, idex_fl, exmem_fl, memwb_fl;
  logic [1:0]  state;
  logic        tmo;
  logic [31:0] c_cyc, c_ret, c_stl, c_fl;

  logic        s_pc_st, s_ifid_st, s_idex_st, s_exmem_st, s_memwb_st;
  logic        s_ifid_fl, s_idex_fl, s_exmem_fl, s_memwb_fl;
  logic [1:0]  s_state;
  logic        s_tmo;
  logic [3:0]  s_cyc, s_ret, s_stl, s_fl;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_prev_wait;
  int          m_bub;
  int          m_run;
  bit          m_tmo;
  longint unsigned m_cyc, m_ret, m_stl, m_fl;

  always #5 i_clk = ~i_clk;

  hazard_ctrl #(.CNT_W(32), .REDIRECT_BUBBLES(BUB), .MEM_TIMEOUT(MT)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_ex_valid(ex_valid), .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd), .i_ex_mispred(ex_mispred),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready), .i_wb_valid(wb_valid), .i_wb_bubble(wb_bubble),
    .o_pc_stall(pc_st), .o_ifid_stall(ifid_st), .o_idex_stall(idex_st), .o_exmem_stall(exmem_st),
    .o_memwb_stall(memwb_st), .o_ifid_flush(ifid_fl), .o_idex_flush(idex_fl),
    .o_exmem_flush(exmem_fl), .o_memwb_flush(memwb_fl), .o_state(state), .o_mem_timeout(tmo),
    .o_cnt_cycle(c_cyc), .o_cnt_retire(c_ret), .o_cnt_stall(c_stl), .o_cnt_flush(c_fl)
  );

  hazard_ctrl #(.CNT_W(4), .REDIRECT_BUBBLES(BUB), .MEM_TIMEOUT(MT)) u_small (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_ex_valid(ex_valid), .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd), .i_ex_mispred(ex_mispred),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready), .i_wb_valid(wb_valid), .i_wb_bubble(wb_bubble),
    .o_pc_stall(s_pc_st), .o_ifid_stall(s_ifid_st), .o_idex_stall(s_idex_st), .o_exmem_stall(s_exmem_st),
    .o_memwb_stall(s_memwb_st), .o_ifid_flush(s_ifid_fl), .o_idex_flush(s_idex_fl),
    .o_exmem_flush(s_exmem_fl), .o_memwb_flush(s_memwb_fl), .o_state(s_state), .o_mem_timeout(s_tmo),
    .o_cnt_cycle(s_cyc), .o_cnt_retire(s_ret), .o_cnt_stall(s_stl), .o_cnt_flush(s_fl)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned v, input longint unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; ex_mispred = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1; wb_valid = 1'b1; wb_bubble = 1'b0;
  endtask

  task automatic model_reset();
    m_prev_wait = 0; m_bub = 0; m_run = 0; m_tmo = 0;
    m_cyc = 0; m_ret = 0; m_stl = 0; m_fl = 0;
  endtask

  // Check all outputs against the model for the current inputs, then clock once.
  task automatic run_cycle();
    bit w, mp, lu, redir, e_pc, e_ifid_fl, e_idex_fl;
    int e_state;
    #1;
    w  = mem_req & !mem_ready;
    mp = ex_valid & ex_mispred;
    lu = ex_valid & ex_mem_read & (ex_rd != 0) &
         ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    redir     = (m_bub > 0);
    e_pc      = w | (!mp & lu);
    e_ifid_fl = !w & (mp | (!lu & redir));
    e_idex_fl = !w & (mp | lu);
    e_state   = m_prev_wait ? 1 : (redir ? 2 : 0);
    check("pc_stall",    pc_st,    e_pc);
    check("ifid_stall",  ifid_st,  e_pc);
    check("idex_stall",  idex_st,  w);
    check("exmem_stall", exmem_st, w);
    check("memwb_stall", memwb_st, 0);
    check("ifid_flush",  ifid_fl,  e_ifid_fl);
    check("idex_flush",  idex_fl,  e_idex_fl);
    check("exmem_flush", exmem_fl, 0);
    check("memwb_flush", memwb_fl, w);
    check("state",       state,    e_state);
    check("timeout",     tmo,      m_tmo);
    check("cnt_cycle",   c_cyc,    sat(m_cyc, MAX32));
    check("cnt_retire",  c_ret,    sat(m_ret, MAX32));
    check("cnt_stall",   c_stl,    sat(m_stl, MAX32));
    check("cnt_flush",   c_fl,     sat(m_fl, MAX32));
    check("s_cnt_cycle", s_cyc,    sat(m_cyc, MAX4));
    check("s_cnt_stall", s_stl,    sat(m_stl, MAX4));
    @(posedge i_clk);
    m_cyc++;
    if (wb_valid && !wb_bubble) m_ret++;
    if (e_pc) m_stl++;
    if (mp && !w) m_fl++;
    if (w) begin
      m_prev_wait = 1; m_bub = 0; m_run++;
      if (m_run == MT) m_tmo = 1;
    end else begin
      m_prev_wait = 0; m_run = 0;
      m_bub = mp ? BUB : ((m_bub > 0) ? m_bub - 1 : 0);
    end
    @(negedge i_clk);
  endtask

  initial begin
    idle();
    model_reset();
    i_reset = 1'b0;
    // Outputs must be quiet under reset even with a wait request present.
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_pc_stall", pc_st, 0);
    check("rst_memwb_flush", memwb_fl, 0);
    idle();
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_cnt_cycle", c_cyc, 0);
    @(negedge i_clk);
    m_cyc = 0;
    model_reset();
    // Model restarts counting from the first edge after release, which has passed.
    m_cyc = 1; m_ret = 1;

    // Load-use on rs2, then same with rd=x0.
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1;
    #1; check("lu_pc_stall", pc_st, 1); check("lu_idex_flush", idex_fl, 1);
    run_cycle();
    ex_rd = 5'd0; id_rs2 = 5'd0;
    #1; check("lu_x0_pc_stall", pc_st, 0);
    run_cycle();
    idle(); run_cycle();

    // Three DMEM wait cycles then ready.
    mem_req = 1; mem_ready = 0;
    run_cycle();
    #1; check("wait_state", state, 1);
    run_cycle(); run_cycle();
    mem_ready = 1;
    #1; check("wait_cnt_stall", c_stl, 4);
    run_cycle();
    idle();
    #1; check("wait_back_run", state, 0);
    run_cycle();

    // Mispredict with two trailing bubbles.
    ex_valid = 1; ex_mispred = 1;
    #1; check("mp_ifid_flush", ifid_fl, 1); check("mp_idex_flush", idex_fl, 1);
    check("mp_pc_stall", pc_st, 0);
    run_cycle();
    idle();
    #1; check("bub1_ifid_flush", ifid_fl, 1); check("bub1_idex_flush", idex_fl, 0);
    run_cycle(); run_cycle();
    #1; check("mp_run_again", state, 0); check("mp_cnt_flush", c_fl, 1);
    run_cycle();

    // Mispredict and load-use together: mispredict only.
    ex_valid = 1; ex_mispred = 1; ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1;
    #1; check("mplu_pc_stall", pc_st, 0); check("mplu_ifid_flush", ifid_fl, 1);
    run_cycle();
    idle(); repeat (3) run_cycle();

    // Wait with a pending mispredict, acted on in the ready cycle.
    ex_valid = 1; ex_mispred = 1; mem_req = 1; mem_ready = 0;
    #1; check("wmp_idex_flush", idex_fl, 0); check("wmp_pc_stall", pc_st, 1);
    run_cycle(); run_cycle();
    mem_ready = 1;
    #1; check("rdy_mp_idex_flush", idex_fl, 1); check("rdy_mp_pc_stall", pc_st, 0);
    run_cycle();
    idle();
    #1; check("rdy_mp_redirect", state, 2);
    repeat (3) run_cycle();

    // Timeout: ready held low.
    mem_req = 1; mem_ready = 0;
    repeat (3) run_cycle();
    #1; check("tmo_before", tmo, 0);
    run_cycle();
    #1; check("tmo_set", tmo, 1);
    run_cycle();
    idle(); run_cycle();
    #1; check("tmo_sticky", tmo, 1);
    run_cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      ex_valid    = ($urandom_range(0, 9) < 8);
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_mispred  = ($urandom_range(0, 9) < 2);
      mem_req     = ($urandom_range(0, 9) < 4);
      mem_ready   = ($urandom_range(0, 9) < 6);
      wb_valid    = 1'($urandom_range(0, 1));
      wb_bubble   = 1'($urandom_range(0, 1));
      run_cycle();
    end

    // Reset while in REDIRECT.
    idle();
    ex_valid = 1; ex_mispred = 1;
    run_cycle();
    idle();
    #1; check("pre_rst_redirect", state, 2);
    #1; i_reset = 1'b0;
    #1;
    check("mid_rst_ifid_flush", ifid_fl, 0);
    check("mid_rst_state", state, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    model_reset();
    #1;
    check("rel_state", state, 0);
    check("rel_cnt_cycle", c_cyc, 0);
    check("rel_cnt_retire", c_ret, 0);
    check("rel_cnt_stall", c_stl, 0);
    check("rel_cnt_flush", c_fl, 0);
    check("rel_timeout", tmo, 0);
    check("rel_ifid_flush", ifid_fl, 0);
    check("rel_idex_flush", idex_fl, 0);

    // 20 cycles on the 4-bit counter instance saturate at 15.
    repeat (20) run_cycle();
    #1; check("small_cnt_cycle_sat", s_cyc, 15);
    check("cnt_cycle_20", c_cyc, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
